goomba_life_ctrl: RTL and testbench

- Lifecycle controller and collision scheduler for up to NUM_GOOMBA goomba_display instances.
- Once per frame_tick, scans the slots serially, one per clk, and checks each slot's rectangle against Mario's.
- Sequences each slot through ALIVE, SQUASHED and DEAD, then respawns it by pulsing that instance's reset.
- Produces stomp/hit events and a saturating score for the game top level.

---
 rtl/goomba_life_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_goomba_life_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goomba_life_ctrl.sv
// goomba_life_ctrl
//   Lifecycle controller and collision scheduler for NUM_GOOMBA goomba_display
//   instances. Each frame_tick starts a serial scan that visits one slot per
//   clk. The scan tests the slot's rectangle against Mario's rectangle. It then
//   advances that slot through ALIVE -> SQUASHED -> DEAD -> ALIVE, pulsing the
//   slot's goomba_rst on respawn.
//
//   Ports
//     clk, rst            system clock, synchronous active-high reset
//     frame_tick          one-cycle frame strobe, starts a scan when idle
//     mario_left/top      Mario position (10-bit x/y)
//     mario_falling       Mario moving downward (needed for a stomp)
//     goomba_left_bus     slot k x at [10k+9:10k]
//     goomba_top_bus      slot k y, same packing
//     goomba_alive        slot in ALIVE
//     goomba_squash       slot in SQUASHED (squashed sprite select)
//     goomba_visible      slot not DEAD
//     goomba_rst          one-cycle respawn reset per slot
//     stomp_pulse         one cycle per stomp
//     mario_hit_pulse     one cycle per accepted hit
//     score               saturating stomp score
//     busy                scan in progress
//     scan_overrun        sticky: frame_tick seen while busy
//     combo               (GOOMBA_COMBO_EN only) stomp combo level 0..3
//
//   Build option: define GOOMBA_COMBO_EN to add the combo output. With combo,
//   each stomp scores 1<<combo.
//
//   Slot states
//     state        | meaning
//     ST_ALIVE     | walking, collides with Mario
//     ST_SQUASHED  | showing squashed sprite, timer counts frames down
//     ST_DEAD      | invisible, timer counts down to respawn
module goomba_life_ctrl #(
    parameter int NUM_GOOMBA     = 4,
    parameter int GOOMBA_W       = 26,
    parameter int GOOMBA_H       = 27,
    parameter int MARIO_W        = 29,
    parameter int MARIO_H        = 39,
    parameter int STOMP_MARGIN   = 8,
    parameter int SQUASH_FRAMES  = 30,
    parameter int RESPAWN_FRAMES = 180,
    parameter int HIT_COOLDOWN   = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic [9:0]              mario_left,
    input  logic [9:0]              mario_top,
    input  logic                    mario_falling,
    input  logic [10*NUM_GOOMBA-1:0] goomba_left_bus,
    input  logic [10*NUM_GOOMBA-1:0] goomba_top_bus,
    output logic [NUM_GOOMBA-1:0]   goomba_alive,
    output logic [NUM_GOOMBA-1:0]   goomba_squash,
    output logic [NUM_GOOMBA-1:0]   goomba_visible,
    output logic [NUM_GOOMBA-1:0]   goomba_rst,
    output logic                    stomp_pulse,
    output logic                    mario_hit_pulse,
    output logic [7:0]              score,
    output logic                    busy,
`ifdef GOOMBA_COMBO_EN
    output logic [1:0]              combo,
`endif
    output logic                    scan_overrun
);

    localparam int IDX_W   = (NUM_GOOMBA > 1) ? $clog2(NUM_GOOMBA) : 1;
    localparam int TMR_MAX = (SQUASH_FRAMES > RESPAWN_FRAMES) ? SQUASH_FRAMES : RESPAWN_FRAMES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int CD_W    = (HIT_COOLDOWN > 0) ? $clog2(HIT_COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        ST_ALIVE    = 2'd0,
        ST_SQUASHED = 2'd1,
        ST_DEAD     = 2'd2
    } slot_state_t;

    slot_state_t            state_q [NUM_GOOMBA];
    slot_state_t            state_d [NUM_GOOMBA];
    logic [TMR_W-1:0]       timer_q [NUM_GOOMBA];
    logic [TMR_W-1:0]       timer_d [NUM_GOOMBA];
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CD_W-1:0]        cooldown_q, cooldown_d;
    logic                   busy_d, overrun_d, stomp_d, hit_d;
    logic [7:0]             score_d;
    logic [NUM_GOOMBA-1:0]  grst_d;
`ifdef GOOMBA_COMBO_EN
    logic [1:0]             combo_d;
`endif

    // Slot currently being visited
    logic [9:0]             sel_left, sel_top;
    slot_state_t            sel_state, nxt_state;
    logic [TMR_W-1:0]       sel_timer, nxt_timer;
    logic                   respawn;

    always_comb begin
        sel_left  = '0;
        sel_top   = '0;
        sel_state = ST_ALIVE;
        sel_timer = '0;
        for (int k = 0; k < NUM_GOOMBA; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_left  = goomba_left_bus[10*k +: 10];
                sel_top   = goomba_top_bus[10*k +: 10];
                sel_state = state_q[k];
                sel_timer = timer_q[k];
            end
        end
    end

    // 11-bit arithmetic keeps right/bottom edges from wrapping near the screen edge
    logic [10:0] ml, mt, gl, gt;
    logic        overlap, is_stomp, is_hit;

    assign ml = {1'b0, mario_left};
    assign mt = {1'b0, mario_top};
    assign gl = {1'b0, sel_left};
    assign gt = {1'b0, sel_top};

    assign overlap  = (ml <= gl + 11'(GOOMBA_W)) && (gl <= ml + 11'(MARIO_W)) &&
                      (mt <= gt + 11'(GOOMBA_H)) && (gt <= mt + 11'(MARIO_H));
    assign is_stomp = overlap && mario_falling &&
                      (mt + 11'(MARIO_H) <= gt + 11'(STOMP_MARGIN));
    assign is_hit   = overlap && !is_stomp;

    logic [8:0] score_inc, score_sum;
    logic [7:0] score_sat;

`ifdef GOOMBA_COMBO_EN
    assign score_inc = 9'd1 << combo;
`else
    assign score_inc = 9'd1;
`endif
    assign score_sum = {1'b0, score} + score_inc;
    assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

    always_comb begin
        busy_d     = busy;
        idx_d      = idx_q;
        cooldown_d = cooldown_q;
        score_d    = score;
        overrun_d  = scan_overrun;
        stomp_d    = 1'b0;
        hit_d      = 1'b0;
        grst_d     = '0;
        nxt_state  = sel_state;
        nxt_timer  = sel_timer;
        respawn    = 1'b0;
`ifdef GOOMBA_COMBO_EN
        combo_d    = combo;
`endif

        if (!busy) begin
            if (frame_tick) begin
                busy_d = 1'b1;
                idx_d  = '0;
                if (cooldown_q != '0) begin
                    cooldown_d = cooldown_q - CD_W'(1);
                end
`ifdef GOOMBA_COMBO_EN
                if (!mario_falling) begin
                    combo_d = 2'd0;
                end
`endif
            end
        end else begin
            if (frame_tick) begin
                overrun_d = 1'b1;
            end

            case (sel_state)
                ST_ALIVE: begin
                    if (is_stomp) begin
                        nxt_state = ST_SQUASHED;
                        nxt_timer = TMR_W'(SQUASH_FRAMES - 1);
                        stomp_d   = 1'b1;
                        score_d   = score_sat;
`ifdef GOOMBA_COMBO_EN
                        if (combo != 2'd3) begin
                            combo_d = combo + 2'd1;
                        end
`endif
                    end else if (is_hit && (cooldown_q == '0)) begin
                        // Cooldown loads right away so later slots in this scan are suppressed
                        hit_d      = 1'b1;
                        cooldown_d = CD_W'(HIT_COOLDOWN);
                    end
                end
                ST_SQUASHED: begin
                    if (sel_timer == '0) begin
                        nxt_state = ST_DEAD;
                        nxt_timer = TMR_W'(RESPAWN_FRAMES - 1);
                    end else begin
                        nxt_timer = sel_timer - TMR_W'(1);
                    end
                end
                ST_DEAD: begin
                    if (sel_timer == '0) begin
                        nxt_state = ST_ALIVE;
                        respawn   = 1'b1;
                    end else begin
                        nxt_timer = sel_timer - TMR_W'(1);
                    end
                end
                default: begin
                    nxt_state = ST_ALIVE;
                    nxt_timer = '0;
                end
            endcase

            if (idx_q == IDX_W'(NUM_GOOMBA - 1)) begin
                busy_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        for (int k = 0; k < NUM_GOOMBA; k++) begin
            state_d[k] = state_q[k];
            timer_d[k] = timer_q[k];
            if (busy && (idx_q == IDX_W'(k))) begin
                state_d[k] = nxt_state;
                timer_d[k] = nxt_timer;
                grst_d[k]  = respawn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_GOOMBA; k++) begin
                state_q[k] <= ST_ALIVE;
                timer_q[k] <= '0;
            end
            idx_q           <= '0;
            cooldown_q      <= '0;
            busy            <= 1'b0;
            scan_overrun    <= 1'b0;
            score           <= 8'd0;
            stomp_pulse     <= 1'b0;
            mario_hit_pulse <= 1'b0;
            goomba_rst      <= '0;
            goomba_alive    <= '1;
            goomba_visible  <= '1;
            goomba_squash   <= '0;
`ifdef GOOMBA_COMBO_EN
            combo           <= 2'd0;
`endif
        end else begin
            for (int k = 0; k < NUM_GOOMBA; k++) begin
                state_q[k]        <= state_d[k];
                timer_q[k]        <= timer_d[k];
                goomba_alive[k]   <= (state_d[k] == ST_ALIVE);
                goomba_squash[k]  <= (state_d[k] == ST_SQUASHED);
                goomba_visible[k] <= (state_d[k] != ST_DEAD);
            end
            idx_q           <= idx_d;
            cooldown_q      <= cooldown_d;
            busy            <= busy_d;
            scan_overrun    <= overrun_d;
            score           <= score_d;
            stomp_pulse     <= stomp_d;
            mario_hit_pulse <= hit_d;
            goomba_rst      <= grst_d;
`ifdef GOOMBA_COMBO_EN
            combo           <= combo_d;
`endif
        end
    end

endmodule

// File: tb/tb_goomba_life_ctrl.sv
// Directed bench for goomba_life_ctrl. A default 4-slot instance covers
// lifecycle, hit cooldown, overrun and reset. A fast 8-slot instance with
// 1-frame timers drives the score into saturation.
module tb_goomba_life_ctrl;
    localparam int NG = 4;
    localparam int SN = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, frame_tick, mario_falling;
    logic [9:0]       mario_left, mario_top;
    logic [10*NG-1:0] gl_bus, gt_bus;
    logic [NG-1:0]    alive, squash, visible, grst;
    logic             stomp, hit, busy, overrun;
    logic [7:0]       score;

    logic             s_rst, s_tick, s_falling;
    logic [9:0]       s_left, s_top;
    logic [10*SN-1:0] s_gl_bus, s_gt_bus;
    logic [SN-1:0]    s_alive, s_squash, s_visible, s_grst;
    logic             s_stomp, s_hit, s_busy, s_overrun;
    logic [7:0]       s_score;
`ifdef GOOMBA_COMBO_EN
    logic [1:0]       combo, s_combo;
`endif

    goomba_life_ctrl u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .mario_left(mario_left), .mario_top(mario_top), .mario_falling(mario_falling),
        .goomba_left_bus(gl_bus), .goomba_top_bus(gt_bus),
        .goomba_alive(alive), .goomba_squash(squash), .goomba_visible(visible),
        .goomba_rst(grst), .stomp_pulse(stomp), .mario_hit_pulse(hit),
        .score(score), .busy(busy),
`ifdef GOOMBA_COMBO_EN
        .combo(combo),
`endif
        .scan_overrun(overrun)
    );

    goomba_life_ctrl #(.NUM_GOOMBA(SN), .SQUASH_FRAMES(1), .RESPAWN_FRAMES(1)) u_sat (
        .clk(clk), .rst(s_rst), .frame_tick(s_tick),
        .mario_left(s_left), .mario_top(s_top), .mario_falling(s_falling),
        .goomba_left_bus(s_gl_bus), .goomba_top_bus(s_gt_bus),
        .goomba_alive(s_alive), .goomba_squash(s_squash), .goomba_visible(s_visible),
        .goomba_rst(s_grst), .stomp_pulse(s_stomp), .mario_hit_pulse(s_hit),
        .score(s_score), .busy(s_busy),
`ifdef GOOMBA_COMBO_EN
        .combo(s_combo),
`endif
        .scan_overrun(s_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Park every slot off to the right, away from Mario.
    task automatic park_all();
        for (int k = 0; k < NG; k++) begin
            gl_bus[10*k +: 10] = 10'(300 + 40*k);
            gt_bus[10*k +: 10] = 10'd300;
        end
    endtask

    task automatic set_slot(input int k, input logic [9:0] x, input logic [9:0] y);
        gl_bus[10*k +: 10] = x;
        gt_bus[10*k +: 10] = y;
    endtask

    int sc_busy, sc_stomp, sc_stomp_slot, sc_hit, sc_hit_slot, sc_grst_cnt;
    logic [NG-1:0] sc_grst_or;

    // One full scan on the main instance; slot c-1 pulses appear after edge c.
    task automatic run_scan();
        sc_busy = 0; sc_stomp = 0; sc_stomp_slot = -1; sc_hit = 0; sc_hit_slot = -1;
        sc_grst_cnt = 0; sc_grst_or = '0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int c = 0; c <= NG; c++) begin
            if (busy) sc_busy++;
            if (c > 0) begin
                if (stomp) begin sc_stomp++; sc_stomp_slot = c - 1; end
                if (hit)   begin sc_hit++;   sc_hit_slot   = c - 1; end
                if (grst != '0) sc_grst_cnt++;
                sc_grst_or |= grst;
            end
            if (c < NG) step();
        end
    endtask

    int acc_stomp, acc_hit, acc_grst;
    int s_cnt, s_total;

    task automatic run_sat_scan();
        s_cnt = 0;
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        for (int c = 1; c <= SN; c++) begin
            step();
            if (s_stomp) s_cnt++;
        end
        s_total += s_cnt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; frame_tick = 1'b0; mario_falling = 1'b0;
        mario_left = 10'd0; mario_top = 10'd0;
        gl_bus = '0; gt_bus = '0;
        park_all();
        s_rst = 1'b1; s_tick = 1'b0; s_falling = 1'b1;
        s_left = 10'd100; s_top = 10'd169;
        for (int k = 0; k < SN; k++) begin
            s_gl_bus[10*k +: 10] = 10'd100;
            s_gt_bus[10*k +: 10] = 10'd200;
        end
        s_total = 0;
        step(); step();
        rst = 1'b0; s_rst = 1'b0;

        // reset state
        check_val("rst_alive", 32'(alive), 32'hF);
        check_val("rst_visible", 32'(visible), 32'hF);
        check_val("rst_squash", 32'(squash), 32'h0);
        check_val("rst_pulses", {29'd0, grst != '0, stomp, hit}, 32'h0);
        check_val("rst_score_busy_ovr", {22'd0, score, busy, overrun}, 32'h0);

        // idle scan, no overlap
        run_scan();
        check_val("idle_busy_cycles", 32'(sc_busy), 32'd4);
        check_val("idle_pulses", 32'(sc_stomp + sc_hit + sc_grst_cnt), 32'd0);
        check_val("idle_alive", 32'(alive), 32'hF);
        check_val("idle_score", 32'(score), 32'd0);

        // stomp on slot 2: bottom 169+39=208 equals top+margin 200+8 (edge of stomp window)
        set_slot(2, 10'd100, 10'd200);
        mario_left = 10'd100; mario_top = 10'd169; mario_falling = 1'b1;
        run_scan();
        check_val("stomp_count", 32'(sc_stomp), 32'd1);
        check_val("stomp_slot", 32'(sc_stomp_slot), 32'd2);
        check_val("stomp_no_hit", 32'(sc_hit), 32'd0);
        check_val("stomp_squash", 32'(squash), 32'b0100);
        check_val("stomp_alive", 32'(alive), 32'b1011);
        check_val("stomp_score", 32'(score), 32'd1);

        acc_stomp = 0; acc_hit = 0; acc_grst = 0;
        for (int t = 0; t < 29; t++) begin
            run_scan();
            acc_stomp += sc_stomp; acc_hit += sc_hit; acc_grst += sc_grst_cnt;
        end
        check_val("squash_hold_29", 32'(squash), 32'b0100);
        check_val("squash_visible_29", 32'(visible), 32'hF);
        run_scan();
        acc_stomp += sc_stomp; acc_hit += sc_hit; acc_grst += sc_grst_cnt;
        check_val("dead_visible_30", 32'(visible), 32'b1011);
        check_val("dead_squash_30", 32'(squash), 32'b0000);
        for (int t = 0; t < 179; t++) begin
            run_scan();
            acc_stomp += sc_stomp; acc_hit += sc_hit; acc_grst += sc_grst_cnt;
        end
        check_val("dead_hold_alive", 32'(alive), 32'b1011);
        check_val("dead_no_events", 32'(acc_stomp + acc_hit + acc_grst), 32'd0);
        run_scan();
        check_val("respawn_grst_cycles", 32'(sc_grst_cnt), 32'd1);
        check_val("respawn_grst_slot", 32'(sc_grst_or), 32'b0100);
        check_val("respawn_alive", 32'(alive), 32'hF);
        check_val("respawn_grst_low", 32'(grst), 32'h0);

        // hits: bottom 209 > 208, so falling still counts as a hit, not a stomp
        park_all();
        set_slot(0, 10'd100, 10'd200);
        set_slot(1, 10'd100, 10'd200);
        mario_top = 10'd170; mario_falling = 1'b1;
        run_scan();
        check_val("hit_count", 32'(sc_hit), 32'd1);
        check_val("hit_slot", 32'(sc_hit_slot), 32'd0);
        check_val("hit_no_stomp", 32'(sc_stomp), 32'd0);
        check_val("hit_alive", 32'(alive), 32'hF);
        mario_falling = 1'b0;
        acc_hit = 0;
        for (int t = 2; t <= 60; t++) begin
            run_scan();
            acc_hit += sc_hit;
        end
        check_val("hit_cooldown_quiet", 32'(acc_hit), 32'd0);
        run_scan();
        check_val("hit_after_cooldown", 32'(sc_hit), 32'd1);
        check_val("hit_after_slot", 32'(sc_hit_slot), 32'd0);

        // overrun: frame_tick held into the scan
        mario_left = 10'd0; mario_top = 10'd0;
        park_all();
        frame_tick = 1'b1;
        step();
        check_val("ovr_busy_start", {30'd0, busy, overrun}, 32'b10);
        step();
        frame_tick = 1'b0;
        check_val("ovr_set", 32'(overrun), 32'd1);
        step(); step(); step();
        check_val("ovr_scan_not_restarted", 32'(busy), 32'd0);
        run_scan();
        check_val("ovr_sticky", 32'(overrun), 32'd1);
        check_val("ovr_next_scan_len", 32'(sc_busy), 32'd4);

        // reset mid-scan right after a stomp on slot 0
        set_slot(0, 10'd100, 10'd200);
        mario_left = 10'd100; mario_top = 10'd169; mario_falling = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check_val("pre_rst_stomp", 32'(stomp), 32'd1);
        check_val("pre_rst_squash", 32'(squash), 32'b0001);
        check_val("pre_rst_score", 32'(score), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("midrst_alive_vis", {alive, visible}, 32'hFF);
        check_val("midrst_squash_grst", {squash, grst}, 32'h0);
        check_val("midrst_flags", {22'd0, score, busy, overrun}, 32'h0);
        check_val("midrst_pulses", {30'd0, stomp, hit}, 32'h0);

`ifdef GOOMBA_COMBO_EN
        begin
            logic [7:0] exp_score [4];
            logic [1:0] exp_combo [4];
            exp_score = '{8'd1, 8'd3, 8'd7, 8'd15};
            exp_combo = '{2'd1, 2'd2, 2'd3, 2'd3};
            check_val("combo_rst", 32'(combo), 32'd0);
            for (int k = 0; k < NG; k++) begin
                park_all();
                set_slot(k, 10'd100, 10'd200);
                run_scan();
                check_val("combo_score", 32'(score), 32'(exp_score[k]));
                check_val("combo_level", 32'(combo), 32'(exp_combo[k]));
            end
            park_all();
            mario_falling = 1'b0;
            run_scan();
            check_val("combo_clear", 32'(combo), 32'd0);
        end
`endif

        // saturation on the fast instance: 8 stomps every 3rd scan
        run_sat_scan();
`ifdef GOOMBA_COMBO_EN
        check_val("sat_first_score", 32'(s_score), 32'd47);
`else
        check_val("sat_first_score", 32'(s_score), 32'd8);
`endif
        check_val("sat_first_stomps", 32'(s_cnt), 32'd8);
        for (int t = 1; t < 120; t++) run_sat_scan();
        check_val("sat_total_stomps", 32'(s_total), 32'd320);
        check_val("sat_score", 32'(s_score), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
